// File: rtl/oam_dma_if.sv
// CPU-side register access and DMA bus signals of the OAM DMA controller.
// The controller uses the master view; the CPU/bus/OAM environment uses the slave view.
interface oam_dma_if;
  logic [15:0] a;
  logic        cpu_wr;
  logic [7:0]  d_in;
  logic [7:0]  ff46_q;
  logic        dma_active;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;

  modport master (
    input  a, cpu_wr, d_in, dma_rdata,
    output ff46_q, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_wdata
  );

  modport slave (
    output a, cpu_wr, d_in, dma_rdata,
    input  ff46_q, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_wdata
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// FF46 OAM DMA: latches a source page on a CPU write, then copies NBYTES bytes
// from {page,00h..} into OAM, one byte per SLOT_CLKS-clock slot.
module oam_dma_ctrl #(
  parameter int SLOT_CLKS = 4,
  parameter int NBYTES    = 160
) (
  input  logic     clk,
  input  logic     nreset,
  oam_dma_if.master bus
);
  localparam int             PW       = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [PW-1:0]  LAST_PH  = PW'(SLOT_CLKS - 1);
  localparam logic [8:0]     LAST_IDX = 9'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, XFER, FLUSH} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg;
  logic [8:0]    idx_reg;
  logic [7:0]    ff46_reg;
  logic [7:0]    page_reg;
  logic          oam_wr_reg;
  logic [7:0]    oam_addr_reg;
  logic [7:0]    oam_wdata_reg;

  logic trigger;
  logic slot_end;
  logic capture;

  assign trigger  = bus.cpu_wr && (bus.a == 16'hFF46);
  assign slot_end = (phase_reg == LAST_PH);
  assign capture  = (state_reg == XFER) && slot_end;

  always_comb begin
    state_next = state_reg;
    if (trigger) begin
      state_next = START;
    end else begin
      case (state_reg)
        START:   if (slot_end) state_next = XFER;
        XFER:    if (slot_end && idx_reg == LAST_IDX) state_next = FLUSH;
        FLUSH:   if (slot_end) state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // The OAM strobe register doubles as the write-pending mark: it is set by the
  // capture edge, so the write lands on phase 0 of the following slot, and a
  // restart clears it before it can be issued.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase_reg     <= '0;
      idx_reg       <= '0;
      ff46_reg      <= 8'hFF;
      page_reg      <= 8'h00;
      oam_wr_reg    <= 1'b0;
      oam_addr_reg  <= 8'h00;
      oam_wdata_reg <= 8'h00;
    end else begin
      oam_wr_reg <= 1'b0;
      if (trigger) begin
        ff46_reg  <= bus.d_in;
        page_reg  <= (bus.d_in >= 8'hE0) ? (bus.d_in & 8'hDF) : bus.d_in;
        phase_reg <= '0;
        idx_reg   <= '0;
      end else begin
        if (state_reg != IDLE)
          phase_reg <= slot_end ? '0 : phase_reg + 1'b1;
        if (capture) begin
          oam_wr_reg    <= 1'b1;
          oam_addr_reg  <= idx_reg[7:0];
          oam_wdata_reg <= bus.dma_rdata;
          if (idx_reg != LAST_IDX)
            idx_reg <= idx_reg + 9'd1;
        end
      end
    end
  end

  assign bus.ff46_q     = ff46_reg;
  assign bus.dma_active = (state_reg == XFER) || (state_reg == FLUSH);
  assign bus.dma_rd     = (state_reg == XFER);
  assign bus.dma_addr   = {page_reg, idx_reg[7:0]};
  assign bus.oam_wr     = oam_wr_reg;
  assign bus.oam_addr   = oam_addr_reg;
  assign bus.oam_wdata  = oam_wdata_reg;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a negedge monitor logs reads, OAM writes and
// dma_active timing; scenario tasks compare the logs with hand-derived values.
module tb_oam_dma_ctrl;
  localparam int S = 4;
  localparam int N = 160;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  oam_dma_if bus();

  oam_dma_ctrl #(.SLOT_CLKS(S), .NBYTES(N)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Source memory model: data is the low address byte XOR 5Ah.
  assign bus.dma_rdata = bus.dma_addr[7:0] ^ 8'h5A;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor logs, labelled with the number of the clock edge that ends the sampled cycle.
  logic [15:0] rd_seq [0:511];
  logic [7:0]  wr_addr [0:511];
  logic [7:0]  wr_data [0:511];
  int rd_n, wr_n, rd_cyc, act_n, act_first, act_last, wr_first, busy_n, trig_lbl;
  logic        rd_prev;
  logic [15:0] rd_last;

  task automatic clear_mon();
    rd_n = 0; wr_n = 0; rd_cyc = 0; act_n = 0; busy_n = 0;
    act_first = -1; act_last = -1; wr_first = -1; rd_prev = 1'b0; rd_last = 16'h0;
  endtask

  always @(negedge clk) begin
    if (bus.oam_wr || bus.dma_rd || bus.dma_active) busy_n++;
    if (bus.oam_wr && wr_n < 512) begin
      wr_addr[wr_n] = bus.oam_addr;
      wr_data[wr_n] = bus.oam_wdata;
      if (wr_n == 0) wr_first = cyc + 1;
      wr_n++;
    end
    if (bus.dma_active) begin
      act_n++;
      if (act_first < 0) act_first = cyc + 1;
      act_last = cyc + 1;
    end
    if (bus.dma_rd) begin
      rd_cyc++;
      if ((!rd_prev || bus.dma_addr != rd_last) && rd_n < 512) begin
        rd_seq[rd_n] = bus.dma_addr;
        rd_n++;
      end
      rd_last = bus.dma_addr;
    end
    rd_prev = bus.dma_rd;
  end

  task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.a = addr; bus.d_in = data; bus.cpu_wr = 1'b1;
    trig_lbl = cyc + 1;
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.a = 16'h0000; bus.d_in = 8'h00;
  endtask

  task automatic wait_reads(input int target, input string name);
    int k;
    for (k = 0; k < 2000 && rd_n < target; k++) @(negedge clk);
    n_cmp++;
    if (rd_n < target) begin
      n_bad++;
      $display("FAIL %s: timeout, reads seen %0d, required %0d", name, rd_n, target);
    end
  endtask

  task automatic check_transfer(input logic [7:0] page, input string name);
    n_cmp++;
    if (rd_n !== N) begin n_bad++; $display("FAIL %s rd_count: got %0d, expected %0d", name, rd_n, N); end
    n_cmp++;
    if (wr_n !== N) begin n_bad++; $display("FAIL %s wr_count: got %0d, expected %0d", name, wr_n, N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (rd_seq[i] !== {page, 8'(i)}) begin
        n_bad++; $display("FAIL %s rd_addr[%0d]: got %h, expected %h", name, i, rd_seq[i], {page, 8'(i)}); break;
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== (8'(i) ^ 8'h5A)) begin
        n_bad++; $display("FAIL %s oam[%0d]: got addr %h data %h, expected addr %h data %h",
                          name, i, wr_addr[i], wr_data[i], 8'(i), 8'(i) ^ 8'h5A); break;
      end
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; bus.a = 16'h0; bus.cpu_wr = 1'b0; bus.d_in = 8'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.ff46_q !== 8'hFF) begin n_bad++; $display("FAIL reset ff46_q: got %h, expected ff", bus.ff46_q); end
    n_cmp++;
    if ({bus.dma_active, bus.dma_rd, bus.oam_wr} !== 3'b000) begin
      n_bad++; $display("FAIL reset strobes: got %b, expected 000", {bus.dma_active, bus.dma_rd, bus.oam_wr});
    end
    n_cmp++;
    if ({bus.dma_addr, bus.oam_addr, bus.oam_wdata} !== 32'h0) begin
      n_bad++; $display("FAIL reset buses: got %h, expected 0", {bus.dma_addr, bus.oam_addr, bus.oam_wdata});
    end
    nreset = 1'b1;
    @(posedge clk); clear_mon();
    repeat (1000) @(posedge clk);
    n_cmp++;
    if (busy_n !== 0) begin n_bad++; $display("FAIL idle strobes: got %0d busy cycles, expected 0", busy_n); end
    n_cmp++;
    if (bus.ff46_q !== 8'hFF) begin n_bad++; $display("FAIL idle ff46_q: got %h, expected ff", bus.ff46_q); end
    $display("reset/idle: ff46_q=%h busy=%0d", bus.ff46_q, busy_n);
  endtask

  task automatic test_basic_copy();
    @(posedge clk); clear_mon();
    write_reg(16'hFF46, 8'hC1);
    repeat (700) @(posedge clk);
    n_cmp++;
    if (bus.ff46_q !== 8'hC1) begin n_bad++; $display("FAIL c1 ff46_q: got %h, expected c1", bus.ff46_q); end
    check_transfer(8'hC1, "c1");
    n_cmp++;
    if (act_n !== (N + 1) * S) begin n_bad++; $display("FAIL c1 active_len: got %0d, expected %0d", act_n, (N + 1) * S); end
    n_cmp++;
    if (act_first - trig_lbl !== S + 1) begin n_bad++; $display("FAIL c1 active_rise: got %0d, expected %0d", act_first - trig_lbl, S + 1); end
    n_cmp++;
    if (act_last - trig_lbl !== (N + 2) * S) begin n_bad++; $display("FAIL c1 active_end: got %0d, expected %0d", act_last - trig_lbl, (N + 2) * S); end
    n_cmp++;
    if (wr_first - trig_lbl !== 2 * S + 1) begin n_bad++; $display("FAIL c1 first_wr: got %0d, expected %0d", wr_first - trig_lbl, 2 * S + 1); end
    n_cmp++;
    if (rd_cyc !== N * S) begin n_bad++; $display("FAIL c1 rd_cycles: got %0d, expected %0d", rd_cyc, N * S); end
    $display("copy c1: reads=%0d writes=%0d active=%0d rise=+%0d first_wr=+%0d", rd_n, wr_n, act_n, act_first - trig_lbl, wr_first - trig_lbl);
  endtask

  task automatic test_echo_fold();
    @(posedge clk); clear_mon();
    write_reg(16'hFF46, 8'hFE);
    repeat (700) @(posedge clk);
    n_cmp++;
    if (bus.ff46_q !== 8'hFE) begin n_bad++; $display("FAIL fe ff46_q: got %h, expected fe", bus.ff46_q); end
    check_transfer(8'hDE, "fe");
    $display("echo fe: first=%h last=%h writes=%0d", rd_seq[0], rd_seq[N - 1], wr_n);
  endtask

  task automatic test_restart();
    @(posedge clk); clear_mon();
    write_reg(16'hFF46, 8'h80);
    wait_reads(51, "restart wait");
    write_reg(16'hFF46, 8'h90);
    n_cmp++;
    if ({bus.dma_active, bus.dma_rd} !== 2'b00) begin
      n_bad++; $display("FAIL restart start_slot: got %b, expected 00", {bus.dma_active, bus.dma_rd});
    end
    repeat (700) @(posedge clk);
    n_cmp++;
    if (wr_n !== 50 + N) begin n_bad++; $display("FAIL restart wr_count: got %0d, expected %0d", wr_n, 50 + N); end
    n_cmp++;
    if (rd_n !== 51 + N) begin n_bad++; $display("FAIL restart rd_count: got %0d, expected %0d", rd_n, 51 + N); end
    for (int i = 0; i < 50 + N; i++) begin
      logic [7:0] ei;
      ei = (i < 50) ? 8'(i) : 8'(i - 50);
      n_cmp++;
      if (wr_addr[i] !== ei || wr_data[i] !== (ei ^ 8'h5A)) begin
        n_bad++; $display("FAIL restart oam[%0d]: got addr %h data %h, expected addr %h data %h",
                          i, wr_addr[i], wr_data[i], ei, ei ^ 8'h5A); break;
      end
    end
    for (int i = 0; i < 51 + N; i++) begin
      logic [15:0] ea;
      ea = (i < 51) ? {8'h80, 8'(i)} : {8'h90, 8'(i - 51)};
      n_cmp++;
      if (rd_seq[i] !== ea) begin
        n_bad++; $display("FAIL restart rd_addr[%0d]: got %h, expected %h", i, rd_seq[i], ea); break;
      end
    end
    $display("restart 80->90: reads=%0d writes=%0d", rd_n, wr_n);
  endtask

  task automatic test_other_addr();
    logic [15:0] addrs [3];
    addrs[0] = 16'hFF45; addrs[1] = 16'hFF47; addrs[2] = 16'h0046;
    @(posedge clk); clear_mon();
    for (int i = 0; i < 3; i++) begin
      write_reg(addrs[i], 8'h11 * 8'(i + 1));
      repeat (20) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.ff46_q !== 8'h90) begin n_bad++; $display("FAIL other %h ff46_q: got %h, expected 90", addrs[i], bus.ff46_q); end
      $display("write %h: ff46_q=%h", addrs[i], bus.ff46_q);
    end
    n_cmp++;
    if (busy_n !== 0) begin n_bad++; $display("FAIL other busy: got %0d busy cycles, expected 0", busy_n); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); clear_mon();
    write_reg(16'hFF46, 8'h12);
    wait_reads(101, "midreset wait");
    @(negedge clk); #2;
    nreset = 1'b0;
    #1;
    n_cmp++;
    if (bus.ff46_q !== 8'hFF) begin n_bad++; $display("FAIL midreset ff46_q: got %h, expected ff", bus.ff46_q); end
    n_cmp++;
    if ({bus.dma_active, bus.dma_rd, bus.oam_wr} !== 3'b000) begin
      n_bad++; $display("FAIL midreset strobes: got %b, expected 000", {bus.dma_active, bus.dma_rd, bus.oam_wr});
    end
    n_cmp++;
    if ({bus.dma_addr, bus.oam_addr, bus.oam_wdata} !== 32'h0) begin
      n_bad++; $display("FAIL midreset buses: got %h, expected 0", {bus.dma_addr, bus.oam_addr, bus.oam_wdata});
    end
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); clear_mon();
    repeat (30) @(posedge clk);
    n_cmp++;
    if (busy_n !== 0) begin n_bad++; $display("FAIL midreset quiet: got %0d busy cycles, expected 0", busy_n); end
    write_reg(16'hFF46, 8'h00);
    repeat (700) @(posedge clk);
    n_cmp++;
    if (bus.ff46_q !== 8'h00) begin n_bad++; $display("FAIL 00 ff46_q: got %h, expected 00", bus.ff46_q); end
    check_transfer(8'h00, "p00");
    $display("reset mid-transfer then 00: reads=%0d writes=%0d", rd_n, wr_n);
  endtask

  initial begin
    clear_mon();
    trig_lbl = 0;
    test_reset();
    test_basic_copy();
    test_echo_fold();
    test_restart();
    test_other_addr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
